height_divider: RTL and testbench

HEIGHT_DIVIDER -- requirements
Module: height_divider

---
 rtl/height_divider.sv | 144 ++++++++++++++
 tb/tb_height_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/height_divider.sv
// height_divider
//   Converts a perpendicular wall distance from the ray tracer into an
//   on-screen wall half-height:
//     out_height = min(floor((HALF_HEIGHT << FRAC_BITS) / in_dist), HALF_HEIGHT)
//   The quotient is produced by an iterative restoring divider that
//   resolves one bit per cycle, MSB first. A zero distance bypasses the
//   divider and reports the full HALF_HEIGHT.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low
//   in_valid    tracer presents a column result
//   in_ready    block is idle and can accept a column result
//   in_dist     unsigned fixed-point distance, FRAC_BITS fractional bits
//   in_column   screen column index
//   in_side     wall side flag
//   out_valid   result available
//   out_ready   downstream consumes the result
//   out_height  wall half-height in pixels
//   out_column  column index carried with the result
//   out_side    side flag carried with the result
module height_divider #(
  parameter int HALF_HEIGHT = 240,
  parameter int FRAC_BITS   = 12,
  parameter int DIST_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [9:0]        in_column,
  input  logic              in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_height,
  output logic [9:0]        out_column,
  output logic              out_side
);

  localparam int HH_W  = $clog2(HALF_HEIGHT + 1);
  localparam int QW    = HH_W + FRAC_BITS;
  localparam int CNT_W = $clog2(QW + 1);
  localparam logic [QW-1:0] NUMER = {HH_W'(HALF_HEIGHT), {FRAC_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state;
  logic [DIST_W-1:0] dist_r;
  logic [DIST_W-1:0] rem_r;
  logic [QW-1:0]     num_r;
  logic [QW-1:0]     quo_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [9:0]        column_r;
  logic              side_r;

  logic [DIST_W:0]   rem_sh;
  logic              fits;
  logic [DIST_W-1:0] rem_next;

  function automatic logic [7:0] clamp_height(input logic [QW-1:0] q);
    if (q > QW'(HALF_HEIGHT)) return 8'(HALF_HEIGHT);
    else                      return q[7:0];
  endfunction

  // One restoring step: bring down the next numerator bit and subtract
  // the divisor when it fits. The remainder always stays below the
  // divisor, so it fits back into DIST_W bits.
  always_comb begin
    rem_sh   = {rem_r, num_r[QW-1]};
    fits     = (rem_sh >= {1'b0, dist_r});
    rem_next = fits ? DIST_W'(rem_sh - {1'b0, dist_r}) : DIST_W'(rem_sh);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_height <= '0;
      out_column <= '0;
      out_side   <= 1'b0;
      dist_r     <= '0;
      rem_r      <= '0;
      num_r      <= '0;
      quo_r      <= '0;
      cnt_r      <= '0;
      column_r   <= '0;
      side_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dist_r   <= in_dist;
            column_r <= in_column;
            side_r   <= in_side;
            rem_r    <= '0;
            num_r    <= NUMER;
            state    <= DIV;
            // A zero distance skips the iterations: an all-ones quotient
            // clamps to HALF_HEIGHT on the very next edge.
            if (in_dist == '0) begin
              quo_r <= '1;
              cnt_r <= CNT_W'(QW);
            end else begin
              quo_r <= '0;
              cnt_r <= '0;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        DIV: begin
          if (cnt_r == CNT_W'(QW)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_height <= clamp_height(quo_r);
            out_column <= column_r;
            out_side   <= side_r;
          end else begin
            rem_r <= rem_next;
            num_r <= num_r << 1;
            quo_r <= {quo_r[QW-2:0], fits};
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after the handshake edge, never alongside it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_height_divider.sv
module tb_height_divider;

  localparam int HH = 240;
  localparam int FB = 12;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dist;
  logic [9:0]    in_column;
  logic          in_side;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_height;
  logic [9:0]    out_column;
  logic          out_side;

  int n_checks = 0;
  int n_fail   = 0;

  height_divider #(.HALF_HEIGHT(HH), .FRAC_BITS(FB), .DIST_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .in_column(in_column), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .out_height(out_height),
    .out_column(out_column), .out_side(out_side)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division of the scaled half-height, clamped.
  function automatic int model_height(input longint d);
    longint q;
    if (d == 0) return HH;
    q = (longint'(HH) << FB) / d;
    return (q > HH) ? HH : int'(q);
  endfunction

  // Present one input, wait for acceptance, then count edges until out_valid.
  task automatic send(input logic [DW-1:0] d, input logic [9:0] col, input logic s,
                      output int lat);
    int w = 0;
    @(negedge clk);
    in_dist = d; in_column = col; in_side = s; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [DW-1:0] d, input logic [9:0] col,
                         input logic s, input int exp_lat);
    int lat;
    send(d, col, s, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_height"}, out_height, model_height(d));
    check({tag, "_column"}, out_column, col);
    check({tag, "_side"}, out_side, s);
    @(posedge clk); #1;
    check({tag, "_consumed"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    int rx;
    int cyc;
    logic [25:0] exp_q[$];
    logic quiet;

    reset = 1'b0; in_valid = 1'b0; in_dist = '0; in_column = '0; in_side = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", {out_height, out_column, out_side}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release_in_ready", in_ready, 1'b1);

    // Directed values
    run_one("d1p0", 24'h001000, 10'd5, 1'b1, 21);
    check("d1p0_abs", out_height, 8'd240);
    run_one("d2p0", 24'h002000, 10'd6, 1'b0, 21);
    run_one("d3p0", 24'h003000, 10'd7, 1'b1, 21);
    run_one("d1000", 24'h3E8000, 10'd8, 1'b0, 21);
    run_one("d0p5", 24'h000800, 10'd9, 1'b1, 21);
    run_one("dzero", 24'h000000, 10'd10, 1'b0, 1);
    run_one("dmax", 24'hFFFFFF, 10'd11, 1'b1, 21);
    run_one("dtiny", 24'h000001, 10'd12, 1'b0, 21);

    // Stall in DONE with out_ready low while new inputs are offered
    out_ready = 1'b0;
    send(24'h002000, 10'd33, 1'b1, lat);
    check("stall_latency", lat, 21);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_dist = DW'($urandom); in_column = 10'($urandom); in_side = 1'($urandom);
      check("stall_hold", {out_valid, in_ready, out_height, out_column, out_side},
            {1'b1, 1'b0, 8'd120, 10'd33, 1'b1});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", out_valid, 1'b0);
    check("stall_release_ready", in_ready, 1'b1);
    quiet = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    check("stall_ignored_input", quiet, 1'b1);

    // Reset 10 cycles into a division
    @(negedge clk);
    in_dist = 24'h001000; in_column = 10'd77; in_side = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_outputs", {out_valid, in_ready, out_height, out_column, out_side}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1'b1);
    quiet = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    check("midrst_no_result", quiet, 1'b1);
    run_one("post_rst", 24'h004000, 10'd78, 1'b0, 21);

    // 640 back-to-back random columns, out_ready held high
    out_ready = 1'b1;
    rx = 0;
    fork
      begin
        for (int i = 0; i < 640; i++) begin
          logic [DW-1:0] d;
          logic s;
          int w;
          d = DW'($urandom) >> $urandom_range(0, 23);
          s = 1'($urandom);
          @(negedge clk);
          in_valid = 1'b1; in_dist = d; in_column = 10'(i); in_side = s;
          w = 0;
          while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
          end
          exp_q.push_back({10'(i), 8'(model_height(d)), s, 7'd0});
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        cyc = 0;
        while (rx < 640 && cyc < 640 * 40) begin
          @(posedge clk); #1;
          cyc++;
          if (out_valid) begin
            logic [25:0] e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '1;
            check("rand_result", {out_column, out_height, out_side},
                  {e[25:16], e[15:8], e[7]});
            rx++;
          end
        end
      end
    join
    check("rand_count", rx, 640);
    check("rand_leftover", exp_q.size(), 0);
    repeat (30) @(posedge clk);
    #1;
    check("rand_no_extra", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
